// File: rtl/shift_pkg.sv
// Shared constants and payload type for the shift issue slice.
// Decoded-op bundle handed from decode to the issue register.
package shift_pkg;

  localparam int SHIFT_DATA_W = 32;
  localparam int SHIFT_SA_W   = 5;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV  = 6'b000111;

  localparam logic [2:0] SHC_NONE = 3'b000;
  localparam logic [2:0] SHC_SRL  = 3'b001;
  localparam logic [2:0] SHC_SRA  = 3'b010;
  localparam logic [2:0] SHC_SLL  = 3'b100;

  typedef struct packed {
    logic [SHIFT_DATA_W-1:0] d;
    logic [SHIFT_SA_W-1:0]   sa;
    logic [2:0]              c;
    logic [4:0]              rd;
    logic                    illegal;
  } shift_pl_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of MIPS32 SPECIAL shift ops.
// Produces d/sa/c/rd/illegal for the issue register.
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [4:0]  rs_lo,
  input  logic [31:0] rt,
  output shift_pl_t   pl
);

  logic       spec;
  logic [5:0] fn;

  assign spec = (instr[31:26] == OPC_SPECIAL);
  assign fn   = instr[5:0];

  // Select control and amount; anything else is an illegal no-op.
  always_comb begin
    pl         = '0;
    pl.rd      = instr[15:11];
    pl.illegal = 1'b0;
    unique case (1'b1)
      spec && (fn == FUNCT_SLL): begin
        pl.d = rt; pl.sa = instr[10:6]; pl.c = SHC_SLL;
      end
      spec && (fn == FUNCT_SRL): begin
        pl.d = rt; pl.sa = instr[10:6]; pl.c = SHC_SRL;
      end
      spec && (fn == FUNCT_SRA): begin
        pl.d = rt; pl.sa = instr[10:6]; pl.c = SHC_SRA;
      end
      spec && (fn == FUNCT_SLLV): begin
        pl.d = rt; pl.sa = rs_lo; pl.c = SHC_SLL;
      end
      spec && (fn == FUNCT_SRLV): begin
        pl.d = rt; pl.sa = rs_lo; pl.c = SHC_SRL;
      end
      spec && (fn == FUNCT_SRAV): begin
        pl.d = rt; pl.sa = rs_lo; pl.c = SHC_SRA;
      end
      default: begin
        pl.c       = SHC_NONE;
        pl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_issue.sv
// Execute-stage issue register with 2-entry skid buffer.
// SHIFT_ISSUE_NOP_DROP_EN: swallow all-zero NOP words.
module shift_issue
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_d,
  output logic [SA_W-1:0]   out_sa,
  output logic [2:0]        out_c,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  issued_cnt
);

  shift_pl_t        dec_pl;
  shift_pl_t        main_q;
  shift_pl_t        skid_q;
  logic             main_v;
  logic             skid_v;
  logic             rdy_q;
  logic             nop;
  logic             acc;
  logic             drn;
  logic [CNT_W-1:0] cnt_q;

  shift_decode u_dec (
    .instr (in_instr),
    .rs_lo (in_rs[4:0]),
    .rt    (in_rt),
    .pl    (dec_pl)
  );

`ifdef SHIFT_ISSUE_NOP_DROP_EN
  assign nop = (in_instr == 32'h0000_0000);
`else
  assign nop = 1'b0;
`endif

  assign acc = in_valid & rdy_q & ~nop;
  assign drn = main_v & out_ready;

  // Main/skid occupancy; skid always refills main first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else if (skid_v) begin
      if (drn) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end
    end else if (acc) begin
      if (!main_v || drn) begin
        main_q <= dec_pl;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec_pl;
        skid_v <= 1'b1;
        rdy_q  <= 1'b0;
      end
    end else if (drn) begin
      main_v <= 1'b0;
    end
  end

  // Saturating count of legal ops handed to the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drn && !main_q.illegal && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_v;
  assign out_d       = main_q.d;
  assign out_sa      = main_q.sa;
  assign out_c       = main_q.c;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue: directed cases plus random traffic
// against a queue-based reference of the decode rules.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_d;
  logic [4:0]  out_sa;
  logic [2:0]  out_c;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] issued_cnt;

  typedef struct {
    logic [31:0] d;
    int          sa;
    int          c;
    int          rd;
    bit          ill;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   n_run = 0;
  int   n_fail = 0;

  shift_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .out_sa      (out_sa),
    .out_c       (out_c),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .issued_cnt  (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   input logic [31:0] rs,
                                   input logic [31:0] rt);
    exp_t e;
    int op, fn;
    op   = int'(ins >> 26);
    fn   = int'(ins % 64);
    e.rd = int'((ins >> 11) % 32);
    if (op == 0 && (fn == 0 || fn == 2 || fn == 3 ||
                    fn == 4 || fn == 6 || fn == 7)) begin
      e.d   = rt;
      e.sa  = (fn >= 4) ? int'(rs % 32) : int'((ins >> 6) % 32);
      e.c   = (fn % 4 == 0) ? 4 : (fn % 4 == 2) ? 1 : 2;
      e.ill = 1'b0;
    end else begin
      e.d   = 0;
      e.sa  = 0;
      e.c   = 0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic bit dropped(input logic [31:0] ins);
`ifdef SHIFT_ISSUE_NOP_DROP_EN
    return ins == 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: check state, then apply the coming edge's transfers.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("cnt", issued_cnt, mcnt);
      if (out_valid && q.size() != 0) begin
        chk("d", out_d, q[0].d);
        chk("sa", out_sa, q[0].sa);
        chk("c", out_c, q[0].c);
        chk("rd", out_rd, q[0].rd);
        chk("ill", out_illegal, q[0].ill);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        if (!e.ill && mcnt != 16'hFFFF) mcnt++;
      end
      if (in_valid && in_ready && !dropped(in_instr))
        q.push_back(ref_dec(in_instr, in_rs, in_rt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins,
                     input logic [31:0] rs,
                     input logic [31:0] rt);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs    = rs;
    in_rt    = rt;
  endtask

  function automatic logic [31:0] srl_op(input logic [4:0] rd);
    return {6'd0, 5'd0, 5'd1, rd, 5'd1, 6'h02};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int r;
    int fns[6] = '{0, 2, 3, 4, 6, 7};
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      w[31:26] = 6'd0;
      w[5:0]   = 6'(fns[$urandom_range(0, 5)]);
    end else if (r == 8) begin
      w[31:26] = 6'd0;
      w[5:0]   = 6'h20;
    end else if (r == 9) begin
      w = 32'h0;
    end
    return w;
  endfunction

  initial begin
    repeat (3) cyc();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_cnt", issued_cnt, 16'h0);
    chk("rst_d", out_d, 32'h0);
    chk("rst_c", out_c, 3'b000);
    rst = 1'b0;
    cyc();

    // SRA, single op
    out_ready = 1'b1;
    put(32'h0004_1883, 32'h0, 32'h8000_0000);
    cyc();
    in_valid = 1'b0;
    chk("sra_valid", out_valid, 1'b1);
    chk("sra_d", out_d, 32'h8000_0000);
    chk("sra_sa", out_sa, 5'd2);
    chk("sra_c", out_c, 3'b010);
    chk("sra_rd", out_rd, 5'd3);
    cyc();
    chk("sra_cnt", issued_cnt, 16'd1);

    // SLLV uses rs[4:0]
    put({6'd0, 5'd1, 5'd2, 5'd5, 5'd9, 6'h04}, 32'h25, 32'h1);
    cyc();
    in_valid = 1'b0;
    chk("sllv_sa", out_sa, 5'd5);
    chk("sllv_c", out_c, 3'b100);
    chk("sllv_d", out_d, 32'h1);
    cyc();

    // Stall: A in main, B in skid, C held
    out_ready = 1'b0;
    put(srl_op(5'd1), 32'h0, 32'd11);
    cyc();
    put(srl_op(5'd2), 32'h0, 32'd22);
    cyc();
    put(srl_op(5'd3), 32'h0, 32'd33);
    cyc();
    cyc();
    chk("stall_d", out_d, 32'd11);
    chk("stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    cyc();
    chk("rel_b", out_d, 32'd22);
    cyc();
    in_valid = 1'b0;
    chk("rel_c", out_d, 32'd33);
    cyc();
    chk("rel_empty", out_valid, 1'b0);
    chk("rel_cnt", issued_cnt, 16'd5);

    // ADD is illegal, flows as no-op, not counted
    put({6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20}, 32'h5, 32'h6);
    cyc();
    in_valid = 1'b0;
    chk("add_ill", out_illegal, 1'b1);
    chk("add_c", out_c, 3'b000);
    chk("add_rd", out_rd, 5'd7);
    cyc();
    chk("add_cnt", issued_cnt, 16'd5);

    // Reset with both entries full
    out_ready = 1'b0;
    put(srl_op(5'd4), 32'h0, 32'd44);
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("full_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_cnt", issued_cnt, 16'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_valid", out_valid, 1'b0);

    // Canonical NOP
    out_ready = 1'b1;
    put(32'h0, 32'h1234, 32'h5678);
    cyc();
    in_valid = 1'b0;
`ifdef SHIFT_ISSUE_NOP_DROP_EN
    chk("nop_valid", out_valid, 1'b0);
    cyc();
    chk("nop_cnt", issued_cnt, 16'd0);
`else
    chk("nop_valid", out_valid, 1'b1);
    chk("nop_sa", out_sa, 5'd0);
    chk("nop_rd", out_rd, 5'd0);
    chk("nop_c", out_c, 3'b100);
    cyc();
    chk("nop_cnt", issued_cnt, 16'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rnd_instr();
      in_rs     = $urandom;
      in_rt     = $urandom;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();

    // Counter saturation
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    put(srl_op(5'd9), 32'h0, 32'hA5);
    for (int i = 0; i < 65536 + 3; i++) cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("sat_cnt", issued_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
